// File: rtl/hazard_unit.sv
// hazard_unit -- pipeline hazard detection and stall/flush control.
//
// Detects load-use hazards and branch operand dependencies on the instruction
// in EX, inserts pipeline bubbles, flushes IF/ID on taken branches and freezes
// the pipeline once a halt opcode reaches ID.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   if_id_rs/rt         source specifiers of the ID instruction
//   if_id_uses_rt       ID instruction reads rt
//   if_id_is_store      ID instruction is a store (rt is store data only)
//   if_id_is_branch     ID instruction is a branch
//   id_branch_taken     ID-stage branch decision
//   if_id_halt          halt opcode in ID
//   id_ex_rd/RegWrite/MemRead  producer in EX
//   pc_write, if_id_write      PC / IF/ID register enables
//   if_id_flush, id_ex_flush   pipeline register flushes
//   stall_active, halted       status
//   stall_cycles        (only with HAZARD_PERF_CNT_EN) saturating stall count
//
// Build option: define HAZARD_PERF_CNT_EN to add the stall_cycles counter.

module hazard_unit #(
  parameter int unsigned REG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  input  logic             if_id_uses_rt,
  input  logic             if_id_is_store,
  input  logic             if_id_is_branch,
  input  logic             id_branch_taken,
  input  logic             if_id_halt,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_RegWrite,
  input  logic             id_ex_MemRead,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             stall_active,
  output logic             halted
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  typedef enum logic [1:0] {StRun, StStall, StHalt} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic match_rs, match_rt, load_use, branch_dep;

  // r0 is never a real destination, so a write to it creates no dependency.
  assign match_rs = id_ex_RegWrite && (id_ex_rd != '0) && (id_ex_rd == if_id_rs);
  assign match_rt = id_ex_RegWrite && (id_ex_rd != '0) && if_id_uses_rt &&
                    (id_ex_rd == if_id_rt);
  // Store data is forwarded MEM-to-MEM, so only the address operand stalls.
  assign load_use   = id_ex_MemRead && (match_rs || (match_rt && !if_id_is_store));
  assign branch_dep = if_id_is_branch && (match_rs || match_rt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    stall_active = 1'b0;
    halted       = 1'b0;
    // Outputs sit at their idle values for as long as reset is held.
    if (rst_n) begin
      unique case (state_q)
        StRun: begin
          if (if_id_halt) begin
            // Halt outranks stall and flush: nothing else is acted on.
            state_d = StHalt;
          end else if (branch_dep || load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            stall_active = 1'b1;
            // A branch waiting on a load needs the value out of MEM: one more bubble.
            if (branch_dep && id_ex_MemRead) begin
              state_d = StStall;
              cnt_d   = 2'd1;
            end
          end else if (id_branch_taken) begin
            if_id_flush = 1'b1;
          end
        end
        StStall: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_flush  = 1'b1;
          stall_active = 1'b1;
          cnt_d        = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
          if (cnt_q <= 2'd1) state_d = StRun;
        end
        StHalt: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          halted      = 1'b1;
        end
        default: begin
          state_d = StRun;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= 16'h0000;
    end else if (stall_active && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_q <= stall_cycles_q + 16'h0001;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

  localparam int unsigned REG_W = 4;

  // Output vector order: {pc_write, if_id_write, if_id_flush, id_ex_flush, stall_active, halted}
  localparam logic [5:0] RUN_O   = 6'b110000;
  localparam logic [5:0] STALL_O = 6'b000110;
  localparam logic [5:0] FLUSH_O = 6'b111000;
  localparam logic [5:0] HALT_O  = 6'b000101;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [REG_W-1:0] if_id_rs, if_id_rt, id_ex_rd;
  logic             if_id_uses_rt, if_id_is_store, if_id_is_branch, id_branch_taken;
  logic             if_id_halt, id_ex_RegWrite, id_ex_MemRead;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush, stall_active, halted;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0]      stall_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: halted flag and number of extra bubbles still owed.
  bit m_halted  = 1'b0;
  int m_bubbles = 0;

  hazard_unit #(.REG_W(REG_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .if_id_rs        (if_id_rs),
    .if_id_rt        (if_id_rt),
    .if_id_uses_rt   (if_id_uses_rt),
    .if_id_is_store  (if_id_is_store),
    .if_id_is_branch (if_id_is_branch),
    .id_branch_taken (id_branch_taken),
    .if_id_halt      (if_id_halt),
    .id_ex_rd        (id_ex_rd),
    .id_ex_RegWrite  (id_ex_RegWrite),
    .id_ex_MemRead   (id_ex_MemRead),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .stall_active    (stall_active),
    .halted          (halted)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] outs();
    return {pc_write, if_id_write, if_id_flush, id_ex_flush, stall_active, halted};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Register-level dependency view: which register (if any) the EX producer writes.
  function automatic bit m_reads_rs();
    int prod;
    prod = (id_ex_RegWrite && id_ex_rd != 0) ? int'(id_ex_rd) : -1;
    return int'(if_id_rs) == prod;
  endfunction

  function automatic bit m_reads_rt();
    int prod;
    prod = (id_ex_RegWrite && id_ex_rd != 0) ? int'(id_ex_rd) : -1;
    return if_id_uses_rt && (int'(if_id_rt) == prod);
  endfunction

  function automatic bit m_branch_dep();
    return if_id_is_branch && (m_reads_rs() || m_reads_rt());
  endfunction

  function automatic bit m_load_use();
    return id_ex_MemRead && (m_reads_rs() || (m_reads_rt() && !if_id_is_store));
  endfunction

  function automatic logic [5:0] model_out();
    if (!rst_n)                        return RUN_O;
    if (m_halted)                      return HALT_O;
    if (m_bubbles > 0)                 return STALL_O;
    if (if_id_halt)                    return RUN_O;
    if (m_branch_dep() || m_load_use()) return STALL_O;
    if (id_branch_taken)               return FLUSH_O;
    return RUN_O;
  endfunction

  // One clock cycle: compare against the model mid-cycle, advance the model at the edge.
  task automatic step();
    @(negedge clk);
    if (!rst_n) begin
      m_halted  = 1'b0;
      m_bubbles = 0;
    end
    check("model", outs(), model_out());
    @(posedge clk);
    if (!rst_n) begin
      m_halted  = 1'b0;
      m_bubbles = 0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_bubbles > 0) begin
      m_bubbles = m_bubbles - 1;
    end else if (if_id_halt) begin
      m_halted = 1'b1;
    end else if (m_branch_dep() && id_ex_MemRead) begin
      m_bubbles = 1;
    end
    #1;
  endtask

  task automatic set_idle();
    if_id_rs        = '0;
    if_id_rt        = '0;
    id_ex_rd        = '0;
    if_id_uses_rt   = 1'b0;
    if_id_is_store  = 1'b0;
    if_id_is_branch = 1'b0;
    id_branch_taken = 1'b0;
    if_id_halt      = 1'b0;
    id_ex_RegWrite  = 1'b0;
    id_ex_MemRead   = 1'b0;
  endtask

  task automatic set_load(input logic [REG_W-1:0] rd);
    id_ex_MemRead  = 1'b1;
    id_ex_RegWrite = 1'b1;
    id_ex_rd       = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    // Reset holds idle outputs even with a live load-use hazard on the inputs.
    set_load(4'd3);
    if_id_rs = 4'd3;
    #2 check("reset_outputs", outs(), RUN_O);
    step();
    rst_n = 1'b1;
    set_idle();
    #2 check("run_idle", outs(), RUN_O);
    step();

    // Case 1: load-use on rs -> single bubble.
    set_load(4'd3);
    if_id_rs = 4'd3;
    #2 check("c1_stall", outs(), STALL_O);
    step();
    set_idle();
    #2 check("c1_after", outs(), RUN_O);
    step();

    // Case 2: branch reading a loaded register -> two bubbles.
    set_load(4'd5);
    if_id_is_branch = 1'b1;
    if_id_rs        = 4'd5;
    #2 check("c2_stall1", outs(), STALL_O);
    step();
    set_idle();
    if_id_is_branch = 1'b1;
    if_id_rs        = 4'd5;
    #2 check("c2_stall2", outs(), STALL_O);
    step();
    #2 check("c2_after", outs(), RUN_O);
    step();

    // Case 3: store data dependency and r0 producer do not stall.
    set_idle();
    set_load(4'd2);
    if_id_is_store = 1'b1;
    if_id_uses_rt  = 1'b1;
    if_id_rt       = 4'd2;
    if_id_rs       = 4'd7;
    #2 check("c3_store", outs(), RUN_O);
    step();
    set_idle();
    id_ex_RegWrite  = 1'b1;
    id_ex_rd        = 4'd0;
    if_id_rs        = 4'd0;
    if_id_is_branch = 1'b1;
    #2 check("c3_r0", outs(), RUN_O);
    step();

    // Case 4: taken branch flush, and stall overriding flush.
    set_idle();
    if_id_is_branch = 1'b1;
    id_branch_taken = 1'b1;
    if_id_rs        = 4'd1;
    #2 check("c4_flush", outs(), FLUSH_O);
    step();
    set_idle();
    set_load(4'd4);
    if_id_rs        = 4'd4;
    id_branch_taken = 1'b1;
    #2 check("c4_stall_no_flush", outs(), STALL_O);
    step();
    // Branch on an ALU result: one bubble only.
    set_idle();
    id_ex_RegWrite  = 1'b1;
    id_ex_rd        = 4'd6;
    if_id_is_branch = 1'b1;
    if_id_uses_rt   = 1'b1;
    if_id_rt        = 4'd6;
    #2 check("c4_alu_branch", outs(), STALL_O);
    step();
    set_idle();
    #2 check("c4_alu_after", outs(), RUN_O);
    step();

    // Case 5a: asynchronous reset in the middle of the two-bubble stall.
    set_load(4'd5);
    if_id_is_branch = 1'b1;
    if_id_rs        = 4'd5;
    step();
    set_idle();
    #1 check("c5_in_stall", outs(), STALL_O);
    #1 rst_n = 1'b0;
    #1 check("c5_async_reset", outs(), RUN_O);
    step();
    rst_n = 1'b1;
    #2 check("c5_after_reset", outs(), RUN_O);
    step();

    // Case 5b: halt together with load-use; halt wins and sticks.
    set_load(4'd3);
    if_id_rs   = 4'd3;
    if_id_halt = 1'b1;
    #2 check("c5_halt_cycle", outs(), RUN_O);
    step();
    for (int i = 0; i < 20; i++) begin
      if_id_halt      = 1'($urandom_range(0, 1));
      id_branch_taken = 1'($urandom_range(0, 1));
      #2 check("c5_halted", outs(), HALT_O);
      step();
    end
    rst_n = 1'b0;
    set_idle();
    step();
    rst_n = 1'b1;

    // Random traffic with small register numbers to provoke matches.
    for (int i = 0; i < 600; i++) begin
      rst_n           = ($urandom_range(0, 29) != 0);
      if_id_rs        = REG_W'($urandom_range(0, 3));
      if_id_rt        = REG_W'($urandom_range(0, 3));
      id_ex_rd        = REG_W'($urandom_range(0, 3));
      if_id_uses_rt   = 1'($urandom_range(0, 1));
      if_id_is_store  = 1'($urandom_range(0, 1));
      if_id_is_branch = 1'($urandom_range(0, 1));
      id_branch_taken = 1'($urandom_range(0, 1));
      if_id_halt      = ($urandom_range(0, 39) == 0);
      id_ex_RegWrite  = 1'($urandom_range(0, 1));
      id_ex_MemRead   = 1'($urandom_range(0, 1));
      step();
    end

`ifdef HAZARD_PERF_CNT_EN
    // Case 6: counter counts stall edges and saturates.
    rst_n = 1'b0;
    set_idle();
    step();
    rst_n = 1'b1;
    set_load(4'd3);
    if_id_rs = 4'd3;
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cycles !== 16'd3) begin
      n_fail++;
      $display("FAIL perf_count3: got %h, expected 0003", stall_cycles);
    end
    for (int i = 0; i < 65531; i++) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cycles !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL perf_fffe: got %h, expected fffe", stall_cycles);
    end
    for (int i = 0; i < 3; i++) @(posedge clk);
    #1;
    n_tests++;
    if (stall_cycles !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL perf_saturate: got %h, expected ffff", stall_cycles);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (stall_cycles !== 16'h0000) begin
      n_fail++;
      $display("FAIL perf_reset: got %h, expected 0000", stall_cycles);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
